// File: rtl/pipeline_hazard_controller_if.sv
// Decode/status inputs and front-end control outputs shared between the ID/EX
// stages and the hazard controller.
interface pipeline_hazard_controller_if;
  logic [4:0] id_rs;
  logic [4:0] id_rt;
  logic       id_uses_rt;
  logic       ex_mem_read;
  logic [4:0] ex_rt;
  logic       ex_branch_taken;
  logic       ex_muldiv_start;
  logic       muldiv_done;
  logic       pc_write;
  logic       if_id_write;
  logic       if_id_flush;
  logic       id_ex_bubble;

  // Pipeline side: supplies decode/status, consumes the stall/flush controls.
  modport master (
    output id_rs, id_rt, id_uses_rt, ex_mem_read, ex_rt,
           ex_branch_taken, ex_muldiv_start, muldiv_done,
    input  pc_write, if_id_write, if_id_flush, id_ex_bubble
  );

  modport slave (
    input  id_rs, id_rt, id_uses_rt, ex_mem_read, ex_rt,
           ex_branch_taken, ex_muldiv_start, muldiv_done,
    output pc_write, if_id_write, if_id_flush, id_ex_bubble
  );
endinterface

// File: rtl/pipeline_hazard_controller.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use bubbles, taken-branch
// flushes and front-end hold while the multi-cycle mul/div unit is busy.
module pipeline_hazard_controller #(
  parameter int FLUSH_CYCLES = 1,
  parameter int MD_TIMEOUT   = 64,
  parameter int STALL_CNT_W  = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  pipeline_hazard_controller_if.slave hz,
  output logic [1:0]             state,
  output logic                   md_timeout,
  output logic [STALL_CNT_W-1:0] stall_cycles
);

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_FLUSH   = 2'd1,
    ST_MD_WAIT = 2'd2
  } state_t;

  localparam logic [2:0] FLUSH_INIT = 3'(FLUSH_CYCLES - 1);
  localparam logic [7:0] MD_LIMIT   = 8'(MD_TIMEOUT);

  state_t     state_q, state_d;
  logic [2:0] flush_cnt, flush_d;
  logic [7:0] wait_cnt, wait_d;
  logic       tmo_set;
  logic       load_use;

  assign state = state_q;

  assign load_use = hz.ex_mem_read && (hz.ex_rt != 5'd0) &&
                    ((hz.ex_rt == hz.id_rs) || (hz.id_uses_rt && (hz.ex_rt == hz.id_rt)));

  always_comb begin
    hz.pc_write     = 1'b1;
    hz.if_id_write  = 1'b1;
    hz.if_id_flush  = 1'b0;
    hz.id_ex_bubble = 1'b0;
    state_d         = ST_RUN;
    flush_d         = flush_cnt;
    wait_d          = wait_cnt;
    tmo_set         = 1'b0;

    case (state_q)
      ST_FLUSH: begin
        hz.if_id_flush  = 1'b1;
        hz.id_ex_bubble = 1'b1;
        flush_d         = flush_cnt - 3'd1;
        state_d         = (flush_cnt <= 3'd1) ? ST_RUN : ST_FLUSH;
      end
      ST_MD_WAIT: begin
        // Completion releases the front end in the same cycle it arrives.
        if (!hz.muldiv_done) begin
          hz.pc_write     = 1'b0;
          hz.if_id_write  = 1'b0;
          hz.id_ex_bubble = 1'b1;
          wait_d          = wait_cnt + 8'd1;
          if (wait_d == MD_LIMIT) begin
            tmo_set = 1'b1;
          end else begin
            state_d = ST_MD_WAIT;
          end
        end
      end
      default: begin
        // RUN, and the unused encoding which recovers to RUN.
        if (hz.ex_branch_taken) begin
          hz.if_id_flush  = 1'b1;
          hz.id_ex_bubble = 1'b1;
          if (FLUSH_CYCLES > 1) begin
            state_d = ST_FLUSH;
            flush_d = FLUSH_INIT;
          end
        end else if (hz.ex_muldiv_start) begin
          hz.pc_write     = 1'b0;
          hz.if_id_write  = 1'b0;
          hz.id_ex_bubble = 1'b1;
          if (!hz.muldiv_done) begin
            state_d = ST_MD_WAIT;
            wait_d  = 8'd1;
          end
        end else if (load_use) begin
          hz.pc_write     = 1'b0;
          hz.if_id_write  = 1'b0;
          hz.id_ex_bubble = 1'b1;
        end
      end
    endcase

    if (rst) begin
      hz.pc_write     = 1'b0;
      hz.if_id_write  = 1'b0;
      hz.if_id_flush  = 1'b0;
      hz.id_ex_bubble = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_RUN;
      flush_cnt    <= 3'd0;
      wait_cnt     <= 8'd0;
      md_timeout   <= 1'b0;
      stall_cycles <= '0;
    end else begin
      state_q    <= state_d;
      flush_cnt  <= flush_d;
      wait_cnt   <= wait_d;
      md_timeout <= md_timeout | tmo_set;
      if (!hz.pc_write && (stall_cycles != '1)) begin
        stall_cycles <= stall_cycles + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Randomized and directed stimulus for the hazard controller, checked by a
// scoreboard fed from a cycle-level reference model.
module tb_pipeline_hazard_controller;
  localparam int FC    = 3;
  localparam int MT    = 8;
  localparam int SW    = 4;
  localparam int EW    = 8 + SW;
  localparam int SMAX  = (1 << SW) - 1;

  logic clk;
  logic rst;
  logic [1:0]    state;
  logic          md_timeout;
  logic [SW-1:0] stall_cycles;

  pipeline_hazard_controller_if hz();

  pipeline_hazard_controller #(
    .FLUSH_CYCLES(FC), .MD_TIMEOUT(MT), .STALL_CNT_W(SW)
  ) dut (
    .clk(clk), .rst(rst), .hz(hz),
    .state(state), .md_timeout(md_timeout), .stall_cycles(stall_cycles)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // scoreboard: {check_regs, pc, ifw, flush, bubble, state, md_timeout, stall}
  logic [EW-1:0] exp_q[$];
  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // reference model: remaining forced-flush cycles, elapsed wait cycles
  int m_mode       = 0;
  int m_flush_left = 0;
  int m_wait       = 0;
  bit m_tmo        = 0;
  int m_stall      = 0;
  bit m_known      = 0;

  task automatic drive(input bit r, input bit br, input bit st, input bit dn,
                       input bit mr, input logic [4:0] e_rt,
                       input logic [4:0] i_rs, input logic [4:0] i_rt, input bit urt);
    bit lu, pc, w, fl, bb;
    logic [EW-1:0] e;
    @(negedge clk);
    rst = r;
    hz.ex_branch_taken = br;
    hz.ex_muldiv_start = st;
    hz.muldiv_done     = dn;
    hz.ex_mem_read     = mr;
    hz.ex_rt           = e_rt;
    hz.id_rs           = i_rs;
    hz.id_rt           = i_rt;
    hz.id_uses_rt      = urt;
    lu = mr && (e_rt != 0) && ((e_rt == i_rs) || (urt && (e_rt == i_rt)));
    e[EW-1]   = m_known;
    e[SW+2:SW+1] = 2'(m_mode);
    e[SW]     = m_tmo;
    e[SW-1:0] = SW'(m_stall);
    {pc, w, fl, bb} = 4'b1100;
    if (r) begin
      {pc, w, fl, bb} = 4'b0000;
      m_mode = 0; m_flush_left = 0; m_wait = 0; m_tmo = 0; m_stall = 0;
      m_known = 1;
    end else begin
      if (m_mode == 1) begin
        {pc, w, fl, bb} = 4'b1111;
        m_flush_left--;
        if (m_flush_left == 0) m_mode = 0;
      end else if (m_mode == 2) begin
        if (dn) begin
          m_mode = 0;
        end else begin
          {pc, w, fl, bb} = 4'b0001;
          m_wait++;
          if (m_wait == MT) begin
            m_tmo = 1;
            m_mode = 0;
          end
        end
      end else if (br) begin
        {pc, w, fl, bb} = 4'b1111;
        if (FC > 1) begin
          m_mode = 1;
          m_flush_left = FC - 1;
        end
      end else if (st) begin
        {pc, w, fl, bb} = 4'b0001;
        if (!dn) begin
          m_mode = 2;
          m_wait = 1;
        end
      end else if (lu) begin
        {pc, w, fl, bb} = 4'b0001;
      end
      if (!pc && m_stall < SMAX) m_stall++;
    end
    e[SW+6:SW+3] = {pc, w, fl, bb};
    exp_q.push_back(e);
  endtask

  task automatic idle(input bit dn);
    drive(0, 0, 0, dn, 0, 5'd0, 5'd0, 5'd0, 0);
  endtask

  // monitor: compares each presented cycle against the oldest expectation
  initial begin
    logic [EW-1:0] e;
    logic [EW-2:0] act;
    forever begin
      @(negedge clk);
      #2;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        act = {hz.pc_write, hz.if_id_write, hz.if_id_flush, hz.id_ex_bubble,
               state, md_timeout, stall_cycles};
        checks++;
        if (e[EW-1]) begin
          if (act !== e[EW-2:0]) begin
            errors++;
            $display("FAIL cycle%0d outputs: got pc/ifw/fl/bub=%b state=%0d tmo=%b stall=%0d, exp pc/ifw/fl/bub=%b state=%0d tmo=%b stall=%0d",
                     cyc, act[SW+6:SW+3], act[SW+2:SW+1], act[SW], act[SW-1:0],
                     e[SW+6:SW+3], e[SW+2:SW+1], e[SW], e[SW-1:0]);
          end
        end else if (act[SW+6:SW+3] !== e[SW+6:SW+3]) begin
          errors++;
          $display("FAIL cycle%0d reset_ctl: got %b exp %b", cyc, act[SW+6:SW+3], e[SW+6:SW+3]);
        end
        cyc++;
      end
    end
  end

  initial begin
    rst = 1'b1;
    hz.ex_branch_taken = 0; hz.ex_muldiv_start = 0; hz.muldiv_done = 0;
    hz.ex_mem_read = 0; hz.ex_rt = 0; hz.id_rs = 0; hz.id_rt = 0; hz.id_uses_rt = 0;

    // reset held with a taken branch present
    drive(1, 1, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0);
    drive(1, 1, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0);
    idle(0);
    // load-use on rs, then the same with rt=0
    drive(0, 0, 0, 0, 1, 5'd8, 5'd8, 5'd1, 0);
    idle(0);
    drive(0, 0, 0, 0, 1, 5'd0, 5'd0, 5'd0, 1);
    drive(0, 0, 0, 0, 1, 5'd9, 5'd2, 5'd9, 1);
    drive(0, 0, 0, 0, 1, 5'd9, 5'd2, 5'd9, 0);
    // branch beats start and load-use
    drive(0, 1, 1, 0, 1, 5'd8, 5'd8, 5'd8, 1);
    idle(0); idle(0); idle(0);
    // mul/div with done five cycles after start
    drive(0, 0, 1, 0, 0, 5'd0, 5'd0, 5'd0, 0);
    repeat (4) idle(0);
    idle(1);
    idle(0);
    // same-cycle completion
    drive(0, 0, 1, 1, 0, 5'd0, 5'd0, 5'd0, 0);
    idle(0);
    // timeout and stickiness, driving stall into saturation
    drive(0, 0, 1, 0, 0, 5'd0, 5'd0, 5'd0, 0);
    repeat (10) idle(0);
    repeat (20) drive(0, 0, 0, 0, 1, 5'd3, 5'd3, 5'd0, 0);
    repeat (3) idle(0);
    drive(1, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0);
    idle(0);

    // randomized traffic with occasional mid-run resets
    for (int i = 0; i < 800; i++) begin
      drive(($urandom_range(0, 99) == 0),
            ($urandom_range(0, 9) == 0),
            ($urandom_range(0, 11) == 0),
            ($urandom_range(0, 5) == 0),
            1'($urandom_range(0, 1)),
            5'($urandom_range(0, 3)),
            5'($urandom_range(0, 3)),
            5'($urandom_range(0, 3)),
            1'($urandom_range(0, 1)));
    end

    @(negedge clk);
    #3;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending, exp 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
